request_unit: RTL and testbench
===============================

# request_unit

Memory request sequencer sitting between the control unit and the memory/cache interface of the single-cycle datapath. It consumes the decoded `MemRead`/`MemWrite`/`halt` controls and returns the `ihit`/`dhit` responses. It drives `iREN`/`dREN`/`dWEN` to memory and produces the PC-advance enable. A bounded-wait watchdog flags a hung memory port, and optional performance counters record request activity.

## Interface
- `TIMEOUT`, 255: cycles a request may wait for its hit before `timeout_err` sets (1..65535).
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  control: current instruction loads (LW).
- `MemWrite`  in  1  control: current instruction stores (SW).
- `halt`  in  1  control: current instruction is HALT.
- `ihit`  in  1  memory: instruction word valid this cycle.
- `dhit`  in  1  memory: data access complete this cycle.
- `iREN`  out  1  instruction read enable.
- `dREN`  out  1  data read enable.
- `dWEN`  out  1  data write enable.
- `pc_en`  out  1  one-cycle pulse: PC advances and register write commits.
- `halted`  out  1  sticky; core stopped.
- `timeout_err`  out  1  sticky watchdog flag.
- `fetch_cnt`, `data_cnt`, `stall_cnt`  out  32 each  performance counters (see Configuration).

## Operation
- States: FETCH, DATA, HALTED. After reset the block is in FETCH.
- FETCH: `iREN`=1, `dREN`=`dWEN`=0.
  - No `ihit`: stay.
  - `ihit` & `halt`: go to HALTED. Halt has priority over any mem op. No `pc_en`.
  - `ihit` & (`MemRead`|`MemWrite`): go to DATA. Latch `dWEN`=`MemWrite` and `dREN`=`MemRead`&~`MemWrite`; write wins if both are set. No `pc_en`.
  - `ihit` with no mem op: `pc_en`=1; stay in FETCH.
- DATA: `iREN`=0. Latched `dREN`/`dWEN` are held constant until `dhit`.
  - `dhit`: `pc_en`=1. Clear `dREN`/`dWEN` and go to FETCH on the next edge.
  - `ihit` is ignored in DATA.
- HALTED: `iREN`=`dREN`=`dWEN`=`pc_en`=0; `halted`=1. Only `RST` exits.
- `dhit` in FETCH or HALTED is ignored.
- Watchdog: a 16-bit wait counter clears on every state change and on every hit. It increments each cycle FETCH lacks `ihit` or DATA lacks `dhit`, and saturates at `TIMEOUT`. When it reaches `TIMEOUT`, `timeout_err` sets and stays set until `RST`. The state machine is not altered.

## Timing
- `iREN`, `halted` and `timeout_err` are Moore outputs, decoded from the registered state and flags.
- `dREN`/`dWEN` are registered: asserted the cycle after the FETCH `ihit` and deasserted the cycle after `dhit`.
- `pc_en` is combinational in the hit cycle: FETCH&`ihit`&~mem&~`halt`, or DATA&`dhit`.
- Latency:
  - non-memory instruction with single-cycle `ihit`: 1 cycle per instruction;
  - LW/SW: ihit cycle plus ≥1 DATA cycle, i.e. 2 cycles minimum with immediate `dhit`.
- Reset values:
  - state FETCH; `iREN`=1 in the first cycle after reset is released, 0 while `RST` is high;
  - `dREN`=`dWEN`=`pc_en`=`halted`=`timeout_err`=0;
  - all counters 0.
- Reset during DATA abandons the access. `dREN`/`dWEN` read 0 on the edge where `RST` is sampled high.
- Control inputs are sampled only on `ihit` cycles in FETCH; they are don't-care otherwise.

## Configuration
- `REQ_PERF_EN` defined:
  - `fetch_cnt` increments on each FETCH `ihit`;
  - `data_cnt` increments on each DATA `dhit`;
  - `stall_cnt` increments each cycle the wait counter increments.
  - All counters wrap modulo 2^32, clear on `RST`, and freeze in HALTED.
- `REQ_PERF_EN` undefined: no counter flops are built, and all three outputs are tied to 32'd0.

## Test plan
- Reset, then `ihit`=1 every cycle with no mem/halt for 4 cycles -> `iREN`=1 and `pc_en`=1 in each of the 4 cycles; `fetch_cnt`=4 with `REQ_PERF_EN`.
- `ihit`+`MemRead`=1, `dhit` arriving 3 cycles later -> `dREN`=1 for exactly 3 cycles, `iREN`=0 in those cycles, single `pc_en` on the `dhit` cycle, `stall_cnt`=2.
- `ihit` with `MemRead`=`MemWrite`=1, then `dhit` next cycle -> `dWEN`=1, `dREN`=0, one `pc_en`.
- `ihit` with `halt`=1 and `MemWrite`=1 -> `dWEN` never asserts; `halted`=1 next cycle; later `ihit`/`dhit` pulses produce no `pc_en` and no enables; counters are unchanged.
- `TIMEOUT`=8 with `ihit` held 0 -> `timeout_err` rises after 8 waiting cycles and remains 1 after `ihit` resumes normal fetching.
- Assert `RST` for 1 cycle while in DATA with `dREN`=1 -> after that edge `dREN`=0, `timeout_err`=0, counters are 0, and the state is back in FETCH with `iREN`=1.

Source files
------------

// File: rtl/request_unit.sv
// request_unit: memory request sequencer between the control unit and the
// memory/cache interface of a single-cycle datapath.
//
// Parameters:
//   TIMEOUT     - cycles a request may wait for its hit before timeout_err sets (1..65535)
// Ports:
//   CLK         - system clock, all state updates on the rising edge
//   RST         - synchronous active-high reset
//   MemRead     - current instruction loads
//   MemWrite    - current instruction stores
//   halt        - current instruction is HALT
//   ihit        - instruction word valid this cycle
//   dhit        - data access complete this cycle
//   iREN        - instruction read enable
//   dREN, dWEN  - registered data read/write enables
//   pc_en       - one-cycle pulse: PC advances and register write commits
//   halted      - sticky, core stopped
//   timeout_err - sticky watchdog flag
//   fetch_cnt, data_cnt, stall_cnt - performance counters
// Configuration:
//   REQ_PERF_EN - when defined, builds the performance counters; otherwise
//                 the counter outputs are tied to zero.
module request_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        halt,
    input  logic        ihit,
    input  logic        dhit,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        pc_en,
    output logic        halted,
    output logic        timeout_err,
    output logic [31:0] fetch_cnt,
    output logic [31:0] data_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {StFetch, StData, StHalted} state_e;

    localparam logic [15:0] Limit = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic        dren_q, dren_d;
    logic        dwen_q, dwen_d;
    logic [15:0] wait_q, wait_d;
    logic        err_q, err_d;
    logic        pc_hit;
    logic        waiting;
    logic        wait_inc;
    logic        fetch_hit;
    logic        data_hit;

    always_comb begin
        state_d   = state_q;
        dren_d    = dren_q;
        dwen_d    = dwen_q;
        pc_hit    = 1'b0;
        waiting   = 1'b0;
        fetch_hit = 1'b0;
        data_hit  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (ihit) begin
                    fetch_hit = 1'b1;
                    if (halt) begin
                        state_d = StHalted;
                    end else if (MemRead || MemWrite) begin
                        state_d = StData;
                        // write wins when both are requested
                        dwen_d  = MemWrite;
                        dren_d  = MemRead & ~MemWrite;
                    end else begin
                        pc_hit = 1'b1;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            StData: begin
                if (dhit) begin
                    data_hit = 1'b1;
                    pc_hit   = 1'b1;
                    state_d  = StFetch;
                    dren_d   = 1'b0;
                    dwen_d   = 1'b0;
                end else begin
                    waiting = 1'b1;
                end
            end
            StHalted: begin
            end
            default: begin
                state_d = StFetch;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase

        // Every state change coincides with a hit, so clearing on !waiting
        // covers both the hit and state-change cases.
        wait_inc = waiting && (wait_q != Limit);
        if (!waiting) begin
            wait_d = 16'd0;
        end else if (wait_inc) begin
            wait_d = wait_q + 16'd1;
        end else begin
            wait_d = wait_q;
        end
        err_d = err_q | (waiting && (wait_d == Limit));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            wait_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Gated by RST so nothing is requested or committed while in reset.
    assign iREN        = (state_q == StFetch) && !RST;
    assign pc_en       = pc_hit && !RST;
    assign dREN        = dren_q;
    assign dWEN        = dwen_q;
    assign halted      = (state_q == StHalted);
    assign timeout_err = err_q;

`ifdef REQ_PERF_EN
    logic [31:0] fetch_cnt_q, data_cnt_q, stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt_q <= 32'd0;
            data_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (fetch_hit) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (data_hit)  data_cnt_q  <= data_cnt_q + 32'd1;
            if (wait_inc)  stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign data_cnt  = data_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = fetch_hit ^ data_hit ^ wait_inc;
    assign fetch_cnt   = 32'd0;
    assign data_cnt    = 32'd0;
    assign stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed stimulus, a transaction-level
// model compared on every negedge, and literal checks on pulse tallies.
module tb_request_unit;

    localparam int unsigned T = 8;
`ifdef REQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, halt = 1'b0, ihit = 1'b0, dhit = 1'b0;
    logic        iREN, dREN, dWEN, pc_en, halted, timeout_err;
    logic [31:0] fetch_cnt, data_cnt, stall_cnt;

    always #5 CLK = ~CLK;

    request_unit #(.TIMEOUT(T)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
        .ihit(ihit), .dhit(dhit), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .pc_en(pc_en),
        .halted(halted), .timeout_err(timeout_err), .fetch_cnt(fetch_cnt),
        .data_cnt(data_cnt), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending access kind (0 none, 1 load, 2 store) plus halt flag.
    bit          armed = 1'b0;
    bit          m_halted = 1'b0;
    int          m_kind = 0;
    int          m_wait = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_fc = '0, m_dc = '0, m_sc = '0;

    function automatic bit waiting_now();
        return !RST && !m_halted && ((m_kind == 0 && !ihit) || (m_kind != 0 && !dhit));
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            armed    <= 1'b1;
            m_halted <= 1'b0;
            m_kind   <= 0;
            m_wait   <= 0;
            m_err    <= 1'b0;
            m_fc     <= '0;
            m_dc     <= '0;
            m_sc     <= '0;
        end else begin
            if (waiting_now()) begin
                m_wait <= (m_wait < int'(T)) ? m_wait + 1 : int'(T);
                if (m_wait + 1 >= int'(T)) m_err <= 1'b1;
                if (m_wait < int'(T)) m_sc <= m_sc + 1;
            end else begin
                m_wait <= 0;
            end
            if (!m_halted) begin
                if (m_kind == 0 && ihit) begin
                    m_fc <= m_fc + 1;
                    if (halt)          m_halted <= 1'b1;
                    else if (MemWrite) m_kind   <= 2;
                    else if (MemRead)  m_kind   <= 1;
                end else if (m_kind != 0 && dhit) begin
                    m_dc   <= m_dc + 1;
                    m_kind <= 0;
                end
            end
        end
    end

    int pc_seen = 0, dren_seen = 0, dwen_seen = 0, iren_seen = 0, overlap_seen = 0;

    always @(negedge CLK) begin
        if (armed) begin
            check("iREN", iREN, !RST && !m_halted && m_kind == 0);
            check("dREN", dREN, m_kind == 1);
            check("dWEN", dWEN, m_kind == 2);
            check("pc_en", pc_en, !RST && !m_halted &&
                  ((m_kind == 0 && ihit && !halt && !MemRead && !MemWrite) ||
                   (m_kind != 0 && dhit)));
            check("halted", halted, m_halted);
            check("timeout_err", timeout_err, m_err);
            check("fetch_cnt", fetch_cnt, PERF ? m_fc : 32'd0);
            check("data_cnt", data_cnt, PERF ? m_dc : 32'd0);
            check("stall_cnt", stall_cnt, PERF ? m_sc : 32'd0);
            if (pc_en) pc_seen++;
            if (dREN) dren_seen++;
            if (dWEN) dwen_seen++;
            if (iREN) iren_seen++;
            if (iREN && dREN) overlap_seen++;
        end
    end

    task automatic drive(input logic r, input logic ih, input logic dh,
                         input logic mr, input logic mw, input logic h);
        RST = r; ihit = ih; dhit = dh; MemRead = mr; MemWrite = mw; halt = h;
        @(posedge CLK);
        #1;
    endtask

    int b_pc, b_dr, b_dw, b_ir, b_ov;

    task automatic snap();
        b_pc = pc_seen; b_dr = dren_seen; b_dw = dwen_seen; b_ir = iren_seen; b_ov = overlap_seen;
    endtask

    initial begin
        // reset
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("rst_iREN_low", iREN, 1'b0);
        check("rst_dREN", dREN, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_err", timeout_err, 1'b0);

        // four back-to-back plain fetches
        snap();
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0);
        check("fetch4_pc", pc_seen - b_pc, 4);
        check("fetch4_iren", iren_seen - b_ir, 4);
        check("fetch4_cnt", fetch_cnt, PERF ? 32'd4 : 32'd0);

        // load with dhit three cycles after the ihit
        snap();
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        check("lw_dren_cycles", dren_seen - b_dr, 3);
        check("lw_overlap", overlap_seen - b_ov, 0);
        check("lw_pc", pc_seen - b_pc, 1);
        check("lw_stall", stall_cnt, PERF ? 32'd2 : 32'd0);
        check("lw_dren_clear", dREN, 1'b0);

        // read+write together: write wins
        snap();
        drive(0, 1, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0, 0);
        check("sw_dwen_cycles", dwen_seen - b_dw, 1);
        check("sw_dren_cycles", dren_seen - b_dr, 0);
        check("sw_pc", pc_seen - b_pc, 1);
        check("sw_data_cnt", data_cnt, PERF ? 32'd2 : 32'd0);

        // watchdog
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0, 0);
        check("wd_before", timeout_err, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        check("wd_set", timeout_err, 1'b1);
        snap();
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
        check("wd_sticky", timeout_err, 1'b1);
        check("wd_resume_pc", pc_seen - b_pc, 3);

        // reset in the middle of a load
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("rd_dren_on", dREN, 1'b1);
        drive(1, 0, 0, 0, 0, 0);
        check("rd_dren_off", dREN, 1'b0);
        check("rd_err_off", timeout_err, 1'b0);
        check("rd_fetch_cnt", fetch_cnt, 32'd0);
        check("rd_stall_cnt", stall_cnt, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        check("rd_iren_back", iREN, 1'b1);

        // halt beats a simultaneous store
        snap();
        drive(0, 1, 0, 0, 1, 1);
        check("halt_flag", halted, 1'b1);
        check("halt_iren", iREN, 1'b0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        check("halt_pc", pc_seen - b_pc, 0);
        check("halt_dwen", dwen_seen - b_dw, 0);
        check("halt_dren", dren_seen - b_dr, 0);
        check("halt_iren_cycles", iren_seen - b_ir, 1);
        check("halt_fetch_cnt", fetch_cnt, PERF ? 32'd1 : 32'd0);
        check("halt_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
        check("halt_data_cnt", data_cnt, 32'd0);
        check("halt_sticky", halted, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
